// File: rtl/ahbl_arbiter_pkg.sv
// Shared definitions for the AHB-Lite arbiter: HTRANS encodings, per-port
// state encoding and a small transfer-classification helper.
package ahbl_arbiter_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // A port is IDLE, holding a captured address phase (BUF), or owning the
   // downstream data phase (DATA). Issue only happens while dst_hready=1, so
   // the downstream address phase of a port always completes in the cycle it
   // is issued and the port moves straight on to DATA.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUF  = 2'b01,
      ST_DATA = 2'b11
   } port_state_e;

   // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do.
   function automatic logic is_active(input logic [1:0] trans);
      return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahbl_arbiter_priority_onehot.sv
// Request vector to one-hot grant. Search starts at the port just above ptr
// and wraps, so ptr = N-1 gives plain lowest-index-first priority and a
// moving ptr gives round-robin.
module ahbl_arbiter_priority_onehot #(
   parameter int N     = 2,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt
);

   logic found;

   // Ports above the pointer first, then wrap round to the ports at or below it.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (i > int'(ptr))) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (i <= int'(ptr))) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahbl_arbiter.sv
// N-port AHB-Lite arbiter in front of one downstream AHB-Lite slave port.
// A live winner passes straight through; a losing request is captured and the
// master stalled until its buffered address phase is issued.
// Build option: AHBL_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration
// (last grant becomes lowest priority); otherwise port 0 has fixed priority.
module ahbl_arbiter
   import ahbl_arbiter_pkg::*;
#(
   parameter int N_PORTS = 2,
   parameter int W_ADDR  = 32,
   parameter int W_DATA  = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_PORTS-1:0]          src_hready,
   output logic [N_PORTS-1:0]          src_hready_resp,
   output logic [N_PORTS-1:0]          src_hresp,
   input  logic [N_PORTS*W_ADDR-1:0]   src_haddr,
   input  logic [N_PORTS-1:0]          src_hwrite,
   input  logic [N_PORTS*2-1:0]        src_htrans,
   input  logic [N_PORTS*3-1:0]        src_hsize,
   input  logic [N_PORTS*3-1:0]        src_hburst,
   input  logic [N_PORTS*4-1:0]        src_hprot,
   input  logic [N_PORTS-1:0]          src_hmastlock,
   input  logic [N_PORTS*W_DATA-1:0]   src_hwdata,
   output logic [N_PORTS*W_DATA-1:0]   src_hrdata,
   output logic [W_ADDR-1:0]           dst_haddr,
   output logic                        dst_hwrite,
   output logic [1:0]                  dst_htrans,
   output logic [2:0]                  dst_hsize,
   output logic [2:0]                  dst_hburst,
   output logic [3:0]                  dst_hprot,
   output logic                        dst_hmastlock,
   output logic [W_DATA-1:0]           dst_hwdata,
   input  logic                        dst_hready,
   input  logic                        dst_hresp,
   input  logic [W_DATA-1:0]           dst_hrdata
);

   localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   port_state_e        st        [N_PORTS];
   logic [W_ADDR-1:0]  buf_addr  [N_PORTS];
   logic [2:0]         buf_size  [N_PORTS];
   logic [2:0]         buf_burst [N_PORTS];
   logic [3:0]         buf_prot  [N_PORTS];
   logic [N_PORTS-1:0] buf_write;
   logic [N_PORTS-1:0] buf_lock;

   logic [N_PORTS-1:0] in_buf, in_data, live, cand, gnt;
   logic [PTR_W-1:0]   rr_ptr;

   // Classify each port: live request this cycle and arbitration candidacy.
   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         in_buf[i]  = (st[i] == ST_BUF);
         in_data[i] = (st[i] == ST_DATA);
         live[i]    = is_active(src_htrans[2*i +: 2]) && src_hready[i] &&
                      ((st[i] == ST_IDLE) || (in_data[i] && dst_hready));
         cand[i]    = !rst && dst_hready && (in_buf[i] || live[i]);
      end
   end

   ahbl_arbiter_priority_onehot #(
      .N     (N_PORTS),
      .PTR_W (PTR_W)
   ) u_prio (
      .req (cand),
      .ptr (rr_ptr),
      .gnt (gnt)
   );

`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
   // Remember the most recent grant so it drops to lowest priority next time.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= PTR_W'(N_PORTS - 1);
      end else begin
         for (int i = 0; i < N_PORTS; i++) begin
            if (gnt[i]) rr_ptr <= PTR_W'(i);
         end
      end
   end
`else
   assign rr_ptr = PTR_W'(N_PORTS - 1);
`endif

   // Port state and capture buffers; grants win over capture, completion frees the port.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_PORTS; i++) begin
            st[i]        <= ST_IDLE;
            buf_addr[i]  <= '0;
            buf_size[i]  <= '0;
            buf_burst[i] <= '0;
            buf_prot[i]  <= '0;
         end
         buf_write <= '0;
         buf_lock  <= '0;
      end else begin
         for (int i = 0; i < N_PORTS; i++) begin
            if (gnt[i]) begin
               st[i] <= ST_DATA;
            end else if (live[i]) begin
               st[i]        <= ST_BUF;
               buf_addr[i]  <= src_haddr[i*W_ADDR +: W_ADDR];
               buf_size[i]  <= src_hsize[i*3 +: 3];
               buf_burst[i] <= src_hburst[i*3 +: 3];
               buf_prot[i]  <= src_hprot[i*4 +: 4];
               buf_write[i] <= src_hwrite[i];
               buf_lock[i]  <= src_hmastlock[i];
            end else if (in_data[i] && dst_hready) begin
               st[i] <= ST_IDLE;
            end
         end
      end
   end

   // Downstream address phase from the winner; always NONSEQ since bursts may be interleaved.
   always_comb begin
      dst_htrans    = HTRANS_IDLE;
      dst_haddr     = '0;
      dst_hwrite    = 1'b0;
      dst_hsize     = '0;
      dst_hburst    = '0;
      dst_hprot     = '0;
      dst_hmastlock = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (gnt[i]) begin
            dst_htrans = HTRANS_NONSEQ;
            if (in_buf[i]) begin
               dst_haddr     = buf_addr[i];
               dst_hwrite    = buf_write[i];
               dst_hsize     = buf_size[i];
               dst_hburst    = buf_burst[i];
               dst_hprot     = buf_prot[i];
               dst_hmastlock = buf_lock[i];
            end else begin
               dst_haddr     = src_haddr[i*W_ADDR +: W_ADDR];
               dst_hwrite    = src_hwrite[i];
               dst_hsize     = src_hsize[i*3 +: 3];
               dst_hburst    = src_hburst[i*3 +: 3];
               dst_hprot     = src_hprot[i*4 +: 4];
               dst_hmastlock = src_hmastlock[i];
            end
         end
      end
   end

   // Upstream responses and write-data routing from the data-phase owner.
   always_comb begin
      dst_hwdata = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         src_hready_resp[i] = rst || (st[i] == ST_IDLE) || (in_data[i] && dst_hready);
         src_hresp[i]       = !rst && in_data[i] && dst_hresp;
         if (!rst && in_data[i]) begin
            dst_hwdata = dst_hwdata | src_hwdata[i*W_DATA +: W_DATA];
         end
      end
   end

   assign src_hrdata = {N_PORTS{dst_hrdata}};

endmodule

// File: tb/tb_ahbl_arbiter.sv
// Directed bench for ahbl_arbiter (2 ports). A transfer-level model checks
// every output on every falling edge; literal expectations pin key cycles.
module tb_ahbl_arbiter;

   localparam int NP = 2;

   typedef struct packed {
      logic [31:0] a;
      logic        w;
      logic [2:0]  sz;
      logic [2:0]  bu;
      logic [3:0]  pr;
      logic        lk;
   } xfer_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  src_hready, src_hready_resp, src_hresp;
   logic [63:0] src_haddr, src_hwdata, src_hrdata;
   logic [1:0]  src_hwrite, src_hmastlock;
   logic [3:0]  src_htrans;
   logic [5:0]  src_hsize, src_hburst;
   logic [7:0]  src_hprot;
   logic [31:0] dst_haddr, dst_hwdata, dst_hrdata;
   logic        dst_hwrite, dst_hmastlock, dst_hready, dst_hresp;
   logic [1:0]  dst_htrans;
   logic [2:0]  dst_hsize, dst_hburst;
   logic [3:0]  dst_hprot;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;
   assign src_hready = src_hready_resp;

   ahbl_arbiter #(.N_PORTS(NP), .W_ADDR(32), .W_DATA(32)) dut (
      .clk(clk), .rst(rst),
      .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
      .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
      .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
      .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
      .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
      .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
      .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata),
      .dst_hready(dst_hready), .dst_hresp(dst_hresp), .dst_hrdata(dst_hrdata)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   function automatic xfer_t live_of(input int i);
      return {src_haddr[i*32 +: 32], src_hwrite[i], src_hsize[i*3 +: 3],
              src_hburst[i*3 +: 3], src_hprot[i*4 +: 4], src_hmastlock[i]};
   endfunction

   // Rotating search starting after 'last'; fixed priority keeps last = NP-1.
   function automatic int pick(input logic [1:0] want, input int last);
      logic [1:0] sh;
      for (int k = 1; k <= NP; k++) begin
         sh = want >> ((last + k) % NP);
         if (sh[0]) return (last + k) % NP;
      end
      return -1;
   endfunction

   // Transfer-level model: pending transfer per master, data-phase owner, last grant.
   initial begin : model
      xfer_t       pend_rec [NP];
      logic        pend_v   [NP];
      int          owner, last, w;
      logic [1:0]  rdy, rq, want, hr;
      logic [31:0] wd;
      xfer_t       rec;
      owner = -1;
      last  = NP - 1;
      for (int i = 0; i < NP; i++) begin
         pend_v[i]   = 1'b0;
         pend_rec[i] = '0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NP; i++) begin
            rdy[i]  = rst || (!pend_v[i] && ((owner != i) || dst_hready));
            rq[i]   = !rst && rdy[i] && src_htrans[i*2+1];
            want[i] = pend_v[i] || rq[i];
         end
         w   = (!rst && dst_hready) ? pick(want, last) : -1;
         rec = (w < 0) ? '0 : (pend_v[w] ? pend_rec[w] : live_of(w));
         hr  = (!rst && owner >= 0 && dst_hresp) ? (2'b01 << owner) : 2'b00;
         wd  = (!rst && owner >= 0) ? src_hwdata[owner*32 +: 32] : 32'h0;
         chk("dst_addr_phase",
             64'({dst_htrans, dst_haddr, dst_hwrite, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock}),
             64'((w < 0) ? 46'h0 : {2'b10, rec}));
         chk("src_hready_resp", 64'(src_hready_resp), 64'(rdy));
         chk("src_hresp", 64'(src_hresp), 64'(hr));
         chk("dst_hwdata", 64'(dst_hwdata), 64'(wd));
         chk("src_hrdata", src_hrdata, {2{dst_hrdata}});
         if (rst) begin
            owner = -1;
            last  = NP - 1;
            for (int i = 0; i < NP; i++) pend_v[i] = 1'b0;
         end else begin
            for (int i = 0; i < NP; i++) begin
               if (i == w) pend_v[i] = 1'b0;
               else if (rq[i]) begin
                  pend_v[i]   = 1'b1;
                  pend_rec[i] = live_of(i);
               end
            end
            if (dst_hready) owner = w;
`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
            if (w >= 0) last = w;
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic [1:0] tr, input logic [31:0] a, input logic wr);
      src_htrans[i*2 +: 2]  = tr;
      src_haddr[i*32 +: 32] = a;
      src_hwrite[i]         = wr;
      src_hsize[i*3 +: 3]   = 3'd2;
      src_hburst[i*3 +: 3]  = 3'd1;
      src_hprot[i*4 +: 4]   = (i == 0) ? 4'h3 : 4'h1;
      src_hmastlock[i]      = 1'b0;
   endtask

   task automatic idle_all();
      drive(0, 2'b00, 32'h0, 1'b0);
      drive(1, 2'b00, 32'h0, 1'b0);
   endtask

   initial begin : stim
      logic [31:0] seq_addr [4];
      rst        = 1'b1;
      src_hwdata = '0;
      dst_hready = 1'b1;
      dst_hresp  = 1'b0;
      dst_hrdata = 32'h0;
      idle_all();
      drive(0, 2'b10, 32'h0000_0044, 1'b0);   // request during reset must not issue
      tick();
      #2;
      chk("rst_hready_resp", 64'(src_hready_resp), 64'h3);
      chk("rst_htrans", 64'(dst_htrans), 64'h0);
      chk("rst_hwdata", 64'(dst_hwdata), 64'h0);
      tick();
      rst = 1'b0;

      // Single master read passes through with zero added latency.
      drive(0, 2'b10, 32'h0000_0010, 1'b0);
      #2;
      chk("t1_htrans", 64'(dst_htrans), 64'h2);
      chk("t1_haddr", 64'(dst_haddr), 64'h10);
      tick();
      idle_all();
      dst_hrdata = 32'hCAFE_0001;
      #2;
      chk("t1_hrdata", src_hrdata, 64'hCAFE_0001_CAFE_0001);
      chk("t1_hready_resp", 64'(src_hready_resp), 64'h3);
      tick();

      // Simultaneous requests: port 0 now, port 1 buffered and issued next cycle.
      drive(0, 2'b10, 32'h0000_0100, 1'b0);
      drive(1, 2'b10, 32'h4000_0000, 1'b1);
      #2;
      chk("t2_haddr_p0", 64'(dst_haddr), 64'h100);
      tick();
      idle_all();
      src_hwdata[63:32] = 32'hDA7A_0001;
      #2;
      chk("t2_haddr_p1", 64'(dst_haddr), 64'h4000_0000);
      chk("t2_hwrite_p1", 64'(dst_hwrite), 64'h1);
      chk("t2_hready_resp_buf", 64'(src_hready_resp), 64'h1);
      tick();
      #2;
      chk("t2_hwdata_p1", 64'(dst_hwdata), 64'hDA7A_0001);
      chk("t2_hready_resp_done", 64'(src_hready_resp), 64'h3);
      tick();

      // Continuous requests from both masters; port 0 keeps sending SEQ.
`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
      seq_addr = '{32'h200, 32'h300, 32'h200, 32'h300};
`else
      seq_addr = '{32'h200, 32'h200, 32'h200, 32'h200};
`endif
      for (int c = 0; c < 4; c++) begin
         drive(0, (c == 0) ? 2'b10 : 2'b11, 32'h0000_0200, 1'b0);
         drive(1, 2'b10, 32'h0000_0300, 1'b0);
         #2;
         chk("t3_grant_addr", 64'(dst_haddr), 64'(seq_addr[c]));
         chk("t3_htrans_nonseq", 64'(dst_htrans), 64'h2);
         tick();
      end
      idle_all();
      repeat (3) tick();

      // Downstream ERROR on port 1 write while port 0 read is buffered.
      drive(1, 2'b10, 32'h0000_0500, 1'b1);
      tick();
      idle_all();
      drive(0, 2'b10, 32'h0000_0600, 1'b0);
      dst_hready = 1'b0;
      dst_hresp  = 1'b1;
      #2;
      chk("t4_err1_hresp", 64'(src_hresp), 64'h2);
      chk("t4_err1_hready_resp", 64'(src_hready_resp), 64'h1);
      chk("t4_err1_htrans", 64'(dst_htrans), 64'h0);
      tick();
      idle_all();
      dst_hready = 1'b1;
      #2;
      chk("t4_err2_hresp", 64'(src_hresp), 64'h2);
      chk("t4_err2_hready_resp", 64'(src_hready_resp), 64'h2);
      chk("t4_err2_haddr", 64'(dst_haddr), 64'h600);
      tick();
      dst_hresp  = 1'b0;
      dst_hrdata = 32'hBEEF_0002;
      #2;
      chk("t4_okay_hresp", 64'(src_hresp), 64'h0);
      chk("t4_okay_hready_resp", 64'(src_hready_resp), 64'h3);
      tick();

      // Downstream stalls three cycles during port 0 write data phase.
      drive(0, 2'b10, 32'h0000_0700, 1'b1);
      tick();
      idle_all();
      src_hwdata[31:0] = 32'h1111_2222;
      drive(1, 2'b10, 32'h0000_0800, 1'b0);
      dst_hready = 1'b0;
      #2;
      chk("t5_stall_hready_resp0", 64'(src_hready_resp), 64'h2);
      chk("t5_stall_htrans", 64'(dst_htrans), 64'h0);
      tick();
      idle_all();
      for (int c = 0; c < 2; c++) begin
         #2;
         chk("t5_stall_hready_resp", 64'(src_hready_resp), 64'h0);
         chk("t5_stall_hwdata", 64'(dst_hwdata), 64'h1111_2222);
         chk("t5_stall_haddr", 64'(dst_haddr), 64'h0);
         tick();
      end
      dst_hready = 1'b1;
      #2;
      chk("t5_release_haddr", 64'(dst_haddr), 64'h800);
      chk("t5_release_hready_resp", 64'(src_hready_resp), 64'h1);
      tick();
      tick();

      // Reset while port 1 sits buffered: the buffered transfer is dropped.
      drive(0, 2'b10, 32'h0000_0900, 1'b0);
      drive(1, 2'b10, 32'h0000_0A00, 1'b0);
      tick();
      idle_all();
      rst = 1'b1;
      #2;
      chk("t6_rst_hready_resp", 64'(src_hready_resp), 64'h3);
      chk("t6_rst_htrans", 64'(dst_htrans), 64'h0);
      tick();
      rst = 1'b0;
      #2;
      chk("t6_after_htrans", 64'(dst_htrans), 64'h0);
      chk("t6_after_hready_resp", 64'(src_hready_resp), 64'h3);
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
